// File: rtl/float_to_double.sv
// rtl/float_to_double.sv - IEEE-754 binary32 to binary64 exact widening converter
//
// Purpose: accepts one binary32 operand per handshake and returns the exactly
// equivalent binary64 value. Zero, infinity, NaN and normal operands take a
// single UNPACK cycle; subnormal operands are normalised one shift per cycle.
//
// Parameters:
//   CANONICAL_NAN  1: every NaN becomes 64'h7FF8000000000000
//                  0: NaN sign and payload are kept, quiet bit forced to 1
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   input_a       binary32 operand
//   input_a_stb   producer: input_a is valid
//   input_a_ack   block is ready to accept an operand (registered)
//   output_z      binary64 result, held outside PUT_Z
//   output_z_stb  output_z is valid (registered)
//   output_z_ack  consumer has taken output_z
module float_to_double #(
  parameter bit CANONICAL_NAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [1:0] {
    GET_A,
    UNPACK,
    NORMALISE,
    PUT_Z
  } state_t;

  state_t      state_q;
  logic [31:0] a_q;
  logic [23:0] m_q;
  logic [10:0] e_q;
  logic [63:0] z_q;
  logic        z_stb_q;
  logic        a_ack_q;

  logic        a_sign;
  logic [7:0]  a_exp;
  logic [22:0] a_frac;
  logic [10:0] exp_norm;
  logic [63:0] unpack_z_d;
  logic        is_subnormal_d;

  assign a_sign   = a_q[31];
  assign a_exp    = a_q[30:23];
  assign a_frac   = a_q[22:0];
  // Rebias 127 -> 1023; 11-bit arithmetic so the sum never wraps.
  assign exp_norm = {3'b000, a_exp} + 11'd896;

  // Result for every class that finishes in UNPACK; subnormals are flagged
  // for the NORMALISE loop instead.
  always_comb begin
    unpack_z_d     = {a_sign, exp_norm, a_frac, 29'b0};
    is_subnormal_d = 1'b0;
    if (a_exp == 8'hFF) begin
      if (a_frac == 23'd0) begin
        unpack_z_d = {a_sign, 11'h7FF, 52'b0};
      end else if (CANONICAL_NAN) begin
        unpack_z_d = 64'h7FF8000000000000;
      end else begin
        unpack_z_d = {a_sign, 11'h7FF, a_frac | 23'h400000, 29'b0};
      end
    end else if (a_exp == 8'h00) begin
      if (a_frac == 23'd0) begin
        unpack_z_d = {a_sign, 63'b0};
      end else begin
        is_subnormal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GET_A;
      a_q     <= 32'd0;
      m_q     <= 24'd0;
      e_q     <= 11'd0;
      z_q     <= 64'd0;
      z_stb_q <= 1'b0;
      a_ack_q <= 1'b0;
    end else begin
      case (state_q)
        GET_A: begin
          if (input_a_stb && a_ack_q) begin
            a_q     <= input_a;
            a_ack_q <= 1'b0;
            state_q <= UNPACK;
          end else begin
            a_ack_q <= 1'b1;
          end
        end

        UNPACK: begin
          if (is_subnormal_d) begin
            // Exponent of 2^-126 with the hidden bit at m[23]; each left shift
            // costs one exponent step, bottoming out at 874 for frac=1.
            m_q     <= {1'b0, a_frac};
            e_q     <= 11'd897;
            state_q <= NORMALISE;
          end else begin
            z_q     <= unpack_z_d;
            z_stb_q <= 1'b1;
            state_q <= PUT_Z;
          end
        end

        NORMALISE: begin
          if (m_q[23]) begin
            z_q     <= {a_sign, e_q, m_q[22:0], 29'b0};
            z_stb_q <= 1'b1;
            state_q <= PUT_Z;
          end else begin
            m_q <= {m_q[22:0], 1'b0};
            e_q <= e_q - 11'd1;
          end
        end

        PUT_Z: begin
          // Ack is only meaningful here, where stb is always high. Returning
          // to GET_A with ack low gives the one-cycle bubble.
          if (output_z_ack) begin
            z_stb_q <= 1'b0;
            state_q <= GET_A;
          end
        end

        default: begin
          state_q <= GET_A;
          a_ack_q <= 1'b0;
          z_stb_q <= 1'b0;
        end
      endcase
    end
  end

  assign input_a_ack  = a_ack_q;
  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;

endmodule

// File: tb/tb_float_to_double.sv
// tb/tb_float_to_double.sv - self-checking bench for float_to_double
module tb_float_to_double;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        output_z_ack;
  logic        ack0, ack1, stb0, stb1;
  logic [63:0] z0, z1;

  int checks = 0;
  int errors = 0;

  logic        exp_valid;
  logic [63:0] exp_z0, exp_z1, hold_z0, hold_z1;

  always #5 clk = ~clk;

  float_to_double #(.CANONICAL_NAN(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(ack0),
    .output_z(z0), .output_z_stb(stb0), .output_z_ack(output_z_ack)
  );

  float_to_double #(.CANONICAL_NAN(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(ack1),
    .output_z(z1), .output_z_stb(stb1), .output_z_ack(output_z_ack)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Value-level model: the binary32 value is re-expressed as a binary64 value.
  function automatic logic [63:0] model(input logic [31:0] a, input bit canon);
    logic        s;
    int          e8, p;
    logic [22:0] f, rest;
    logic [51:0] mant;
    s  = a[31];
    e8 = int'(a[30:23]);
    f  = a[22:0];
    if (e8 == 255) begin
      if (f == 0) return {s, 11'h7FF, 52'd0};
      if (canon) return 64'h7FF8000000000000;
      return {s, 11'h7FF, 1'b1, f[21:0], 29'd0};
    end
    if (e8 == 0 && f == 0) return {s, 63'd0};
    if (e8 != 0) return {s, 11'(e8 - 127 + 1023), f, 29'd0};
    // value = f * 2^-149 = 1.xxx * 2^(p-149), p = index of leading one
    p = 0;
    for (int i = 0; i < 23; i++) if (f[i]) p = i;
    rest    = f;
    rest[p] = 1'b0;
    mant    = {rest, 29'd0} << (23 - p);
    return {s, 11'(p - 149 + 1023), mant};
  endfunction

  function automatic int latency(input logic [31:0] a);
    int p;
    if (a[30:23] != 8'd0 || a[22:0] == 23'd0) return 2;
    p = 0;
    for (int i = 0; i < 23; i++) if (a[i]) p = i;
    return 3 + (23 - p);
  endfunction

  // Per-cycle compare: results must match the model while valid, and hold otherwise.
  always @(negedge clk) begin
    if (reset) begin
      hold_z0 = 64'd0;
      hold_z1 = 64'd0;
    end else begin
      check("stb_pair", stb1, stb0);
      if (stb0) begin
        if (!exp_valid) begin
          check("unexpected_stb", stb0, 1'b0);
        end else begin
          check("z0_model", z0, exp_z0);
          check("z1_model", z1, exp_z1);
          check("ack_low_in_put", ack0, 1'b0);
          hold_z0 = exp_z0;
          hold_z1 = exp_z1;
        end
      end else begin
        check("z0_hold", z0, hold_z0);
        check("z1_hold", z1, hold_z1);
      end
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [63:0] lit0, input logic [63:0] lit1,
                       input int hold, input bit extra_stb, input bit early_ack);
    int n, k;
    n = 0;
    while (!ack0 && n < 50) begin @(negedge clk); n++; end
    check("ack_wait", ack0, 1'b1);
    exp_z0 = model(a, 1'b0);
    exp_z1 = model(a, 1'b1);
    check("model_lit0", exp_z0, lit0);
    check("model_lit1", exp_z1, lit1);
    input_a     = a;
    input_a_stb = 1'b1;
    @(posedge clk);
    exp_valid = 1'b1;
    @(negedge clk);
    input_a_stb  = 1'b0;
    output_z_ack = early_ack;
    check("ack_drop", ack0, 1'b0);
    k = 0;
    while (!stb0 && k < 60) begin @(negedge clk); k++; end
    output_z_ack = 1'b0;
    check("latency", 64'(k + 1), 64'(latency(a)));
    check("z0_literal", z0, lit0);
    check("z1_literal", z1, lit1);
    for (int i = 0; i < hold; i++) begin
      if (extra_stb) begin input_a = 32'h40490FDB; input_a_stb = 1'b1; end
      @(negedge clk);
      check("bp_stb", stb0, 1'b1);
      check("bp_z", z0, lit0);
      check("bp_no_ack", ack0, 1'b0);
    end
    input_a_stb  = 1'b0;
    output_z_ack = 1'b1;
    @(posedge clk);
    exp_valid = 1'b0;
    @(negedge clk);
    output_z_ack = 1'b0;
    check("stb_fall", stb0, 1'b0);
    check("bubble", ack0, 1'b0);
    @(negedge clk);
    check("ack_rise", ack0, 1'b1);
  endtask

  logic [31:0] va [12];
  logic [63:0] ve0[12];
  logic [63:0] ve1[12];

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    va[0]  = 32'h3F800000; ve0[0]  = 64'h3FF0000000000000; ve1[0]  = 64'h3FF0000000000000;
    va[1]  = 32'hC0200000; ve0[1]  = 64'hC004000000000000; ve1[1]  = 64'hC004000000000000;
    va[2]  = 32'h80000000; ve0[2]  = 64'h8000000000000000; ve1[2]  = 64'h8000000000000000;
    va[3]  = 32'h00000000; ve0[3]  = 64'h0000000000000000; ve1[3]  = 64'h0000000000000000;
    va[4]  = 32'h00000001; ve0[4]  = 64'h36A0000000000000; ve1[4]  = 64'h36A0000000000000;
    va[5]  = 32'h007FFFFF; ve0[5]  = 64'h380FFFFFC0000000; ve1[5]  = 64'h380FFFFFC0000000;
    va[6]  = 32'hFF800000; ve0[6]  = 64'hFFF0000000000000; ve1[6]  = 64'hFFF0000000000000;
    va[7]  = 32'h7FA00000; ve0[7]  = 64'h7FFC000000000000; ve1[7]  = 64'h7FF8000000000000;
    va[8]  = 32'hFFC00001; ve0[8]  = 64'hFFF8000020000000; ve1[8]  = 64'h7FF8000000000000;
    va[9]  = 32'h7F7FFFFF; ve0[9]  = 64'h47EFFFFFE0000000; ve1[9]  = 64'h47EFFFFFE0000000;
    va[10] = 32'h00800000; ve0[10] = 64'h3810000000000000; ve1[10] = 64'h3810000000000000;
    va[11] = 32'h00400000; ve0[11] = 64'h3800000000000000; ve1[11] = 64'h3800000000000000;

    reset        = 1'b1;
    input_a      = 32'd0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    exp_valid    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack0, 1'b0);
    check("rst_stb", stb0, 1'b0);
    check("rst_z", z0, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ack_after_rst", ack0, 1'b1);

    do_op(va[0], ve0[0], ve1[0], 5, 1'b1, 1'b0);
    for (int i = 1; i < 12; i++)
      do_op(va[i], ve0[i], ve1[i], i % 3, 1'b0, (i == 2));

    // Abandon a subnormal normalisation part-way through.
    input_a     = 32'h00000001;
    input_a_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_a_stb = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_stb", stb0, 1'b0);
    check("midrst_z", z0, 64'd0);
    check("midrst_ack", ack0, 1'b0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    do_op(32'h3F800000, 64'h3FF0000000000000, 64'h3FF0000000000000, 0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/float_to_double.md
FLOAT_TO_DOUBLE -- requirements
Module: float_to_double

Interface
REQ-001 SHALL have parameter CANONICAL_NAN, default 0, meaning 1 = every NaN output is 64'h7FF8000000000000 and 0 = sign and payload are preserved with the quiet bit forced.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port input_a, input, 32, IEEE-754 binary32 operand.
REQ-005 SHALL have port input_a_stb, input, 1, producer asserts that input_a is valid.
REQ-006 SHALL have port input_a_ack, output, 1, block is ready to accept an operand.
REQ-007 SHALL have port output_z, output, 64, IEEE-754 binary64 result.
REQ-008 SHALL have port output_z_stb, output, 1, output_z is valid.
REQ-009 SHALL have port output_z_ack, input, 1, consumer has taken output_z.

Function
REQ-010 SHALL implement an FSM with four states: GET_A, UNPACK, NORMALISE, PUT_Z.
REQ-011 GET_A: SHALL drive input_a_ack=1; on an edge where input_a_stb=1 and input_a_ack=1, SHALL capture input_a, drive input_a_ack=0 and go to UNPACK.
REQ-012 input_a_ack SHALL be 0 in every state other than GET_A; input_a_stb outside GET_A SHALL be ignored and SHALL NOT be acked.
REQ-013 UNPACK, exp8=0 and frac=0 (±zero): SHALL set output_z={s,63'b0} and go to PUT_Z.
REQ-014 UNPACK, exp8=255 and frac=0 (±inf): SHALL set output_z={s,11'h7FF,52'b0} and go to PUT_Z.
REQ-015 UNPACK, exp8=255 and frac!=0 (NaN): SHALL set output_z to 64'h7FF8000000000000 if CANONICAL_NAN=1, else to {s,11'h7FF,frac|23'h400000,29'b0}, then go to PUT_Z.
REQ-016 UNPACK, normal operand: SHALL set output_z={s,exp8+11'd896,frac,29'b0}, using 11-bit exponent arithmetic, and go to PUT_Z.
REQ-017 UNPACK, subnormal operand (exp8=0, frac!=0): SHALL load a 24-bit mantissa m={1'b0,frac} and an 11-bit exponent e=897, then go to NORMALISE.
REQ-018 NORMALISE: while m[23]=0, SHALL shift m left by 1 and decrement e by 1, one shift per cycle.
REQ-019 NORMALISE: when m[23]=1, SHALL set output_z={s,e,m[22:0],29'b0} and go to PUT_Z.
REQ-020 The NORMALISE shift count N SHALL equal 23 minus the index of the leading one of frac, so N ranges 1..23; e SHALL never underflow (minimum 874).
REQ-021 Latency: output_z_stb SHALL first be high 2 cycles after the accepting edge for zero, inf, NaN and normal operands, and 3+N cycles after it for subnormal operands.
REQ-022 PUT_Z: SHALL hold output_z_stb=1 with output_z stable until an edge where output_z_ack=1, then drive output_z_stb=0 and return to GET_A.
REQ-023 input_a_ack SHALL re-assert on the cycle after the output handshake, so there is a minimum of 1 bubble cycle and never a combinational stb-to-ack path.
REQ-024 output_z_ack while output_z_stb=0 SHALL be ignored.
REQ-025 output_z SHALL hold its last value outside PUT_Z.
REQ-026 All conversions SHALL be exact; the block SHALL have no rounding logic and no exception flags.

Reset
REQ-027 On an edge where reset=1: state SHALL become GET_A, input_a_ack=0, output_z_stb=0, output_z=0, and internal m and e SHALL be cleared.
REQ-028 input_a_ack SHALL rise on the first cycle after reset deasserts.
REQ-029 Reset in any state, including mid-NORMALISE or PUT_Z with the consumer stalled, SHALL abandon the operation and emit no result.

Verification
REQ-030 1.0f: input_a=32'h3F800000 -> output_z=64'h3FF0000000000000, stb high at accept+2.
REQ-031 Negative normal and zero: 32'hC0200000 -> 64'hC004000000000000; 32'h80000000 -> 64'h8000000000000000.
REQ-032 Subnormals: 32'h00000001 -> 64'h36A0000000000000 at accept+26 (N=23); 32'h007FFFFF -> 64'h380FFFFFC0000000 at accept+4 (N=1).
REQ-033 Specials: 32'hFF800000 -> 64'hFFF0000000000000; 32'h7FA00000 -> 64'h7FFC000000000000 with CANONICAL_NAN=0, and 64'h7FF8000000000000 with CANONICAL_NAN=1.
REQ-034 Backpressure: hold output_z_ack=0 for 5 cycles -> output_z_stb stays 1, output_z is unchanged, input_a_ack stays 0, and a second input_a_stb is not acked; ack on cycle 6 -> stb falls and input_a_ack=1 on the next cycle.
REQ-035 Reset mid-operation: assert reset 5 cycles after accepting 32'h00000001 -> output_z_stb is never raised, outputs read 0, and the next operand 32'h3F800000 converts correctly.
